xy_route_stage: RTL and testbench
=================================

XY_ROUTE_STAGE -- requirements
Module: xy_route_stage

Interface
REQ-001 SHALL have parameter PKT_W, default 16, packet width in bits.
REQ-002 SHALL have parameter COORD_W, default 4, width of each signed offset field; dx = packet[PKT_W-1 -: COORD_W], dy = packet[PKT_W-COORD_W-1 -: COORD_W].
REQ-003 SHALL have parameter DEPTH, default 4, input FIFO entries; power of two, >= 2.
REQ-004 SHALL have parameter ARRIVE_DIR, default DIR_LOCAL, travel direction of the feeding link (DIR_LOCAL, DIR_EAST, DIR_WEST, DIR_NORTH, DIR_SOUTH).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_packet, input, PKT_W, incoming packet.
REQ-008 SHALL have port in_valid, input, 1, in_packet valid.
REQ-009 SHALL have port in_ready, output, 1, stage can accept.
REQ-010 SHALL have port out_packet, output, PKT_W, forwarded packet, shared by all outputs.
REQ-011 SHALL have port out_valid, output, 5, one-hot {local, south, north, west, east} = bits [4:0].
REQ-012 SHALL have port out_ready, output-side input, 5, per-direction downstream ready.
REQ-013 SHALL have port occupancy, output, $clog2(DEPTH)+1, FIFO entries held.
REQ-014 SHALL have port err_pulse, output, 1, one-cycle flag for a dropped illegal packet.
REQ-015 SHALL have port err_count, output, 8, saturating count of dropped packets.

Function
REQ-016 SHALL accept a packet on a rising edge where in_valid && in_ready; in_ready = (occupancy != DEPTH), no same-cycle pass-through when full.
REQ-017 SHALL route the FIFO head XY: dx>0 east, dx-1; dx<0 west, dx+1; dx==0 && dy>0 north, dy-1; dx==0 && dy<0 south, dy+1; both zero local, unchanged. All other bits pass unchanged; arithmetic is signed COORD_W, min negative (-8) valid.
REQ-018 SHALL flag illegal: ARRIVE_DIR=DIR_WEST with dx>0; DIR_EAST with dx<0; DIR_NORTH with dx!=0 or dy<0; DIR_SOUTH with dx!=0 or dy>0; DIR_LOCAL never illegal.
REQ-019 SHALL load the routed head into a registered output stage when the stage is empty or its current packet is handshaken that cycle; latency from input acceptance to out_valid is 2 cycles with an empty pipeline.
REQ-020 SHALL hold out_packet and out_valid stable until out_valid[i] && out_ready[i]; ready on non-selected bits is ignored.
REQ-021 SHALL pop an illegal head on the next edge without loading the output stage, assert err_pulse for exactly the following cycle, increment err_count saturating at 255.
REQ-022 SHALL support push and pop on the same edge at any occupancy below DEPTH, occupancy unchanged.
REQ-023 SHALL sustain one packet per cycle when out_ready is held high for the selected direction.
REQ-024 SHALL emit at most one out_valid bit per cycle.

Reset
REQ-025 SHALL on rst_n low immediately clear FIFO pointers, occupancy=0, out_valid=0, out_packet=0, err_pulse=0, err_count=0; in_ready=1 after release.
REQ-026 SHALL discard all in-flight packets on reset mid-operation; no partial output after release.

Structure
REQ-027 SHALL take DIR_* constants, the out_valid bit-index constants and default PKT_W/COORD_W from shared package noc_pkg.
REQ-028 SHALL instantiate one sub-module noc_fifo (parametrised synchronous FIFO, width PKT_W, depth DEPTH, occupancy output).

Verification (PKT_W=16, COORD_W=4)
REQ-029 SHALL check ARRIVE_DIR=DIR_LOCAL, in 0x3200 -> out_valid=00001, out_packet 0x2200, 2 cycles after acceptance.
REQ-030 SHALL check in 0xE100 -> west, 0xF100; in 0x0300 -> north, 0x0200; in 0x0F00 -> south, 0x0000; in 0x0000 -> local, 0x0000.
REQ-031 SHALL check ARRIVE_DIR=DIR_WEST, in 0x1000 -> no out_valid, err_pulse one cycle, err_count 1; following 0xF000 -> west, 0x0000.
REQ-032 SHALL check out_ready=0, DEPTH=4: 5 packets accepted (4 FIFO + 1 output), in_ready=0, occupancy=4; release out_ready -> all delivered in order, one per cycle.
REQ-033 SHALL check rst_n low with occupancy=3 and out_valid set -> outputs 0 at once; no stale packet after release.
REQ-034 SHALL check 256 illegal packets -> err_count holds 255.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: arrival directions, out_valid bit
// positions and default packet geometry.
package noc_pkg;

    typedef enum logic [2:0] {
        DIR_LOCAL,
        DIR_EAST,
        DIR_WEST,
        DIR_NORTH,
        DIR_SOUTH
    } dir_e;

    localparam int OV_EAST  = 0;
    localparam int OV_WEST  = 1;
    localparam int OV_NORTH = 2;
    localparam int OV_SOUTH = 3;
    localparam int OV_LOCAL = 4;

    localparam int PKT_W_DEF   = 16;
    localparam int COORD_W_DEF = 4;

endpackage

// File: rtl/noc_fifo.sv
// Synchronous power-of-two FIFO with show-ahead head and
// occupancy count; caller guards push on full, pop on empty.
module noc_fifo #(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int OW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [OW-1:0] occupancy,
    output logic          full,
    output logic          empty
);

    localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign full    = (occupancy == FULL_CNT);
    assign empty   = (occupancy == '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occupancy <= occupancy + OW'(wr_en) - OW'(rd_en);
        end
    end

endmodule

// File: rtl/xy_route_stage.sv
// XY routing stage: input FIFO, dimension-order route of the
// head packet, illegal-turn drop, registered output stage.
module xy_route_stage
    import noc_pkg::*;
#(
    parameter  int   PKT_W      = PKT_W_DEF,
    parameter  int   COORD_W    = COORD_W_DEF,
    parameter  int   DEPTH      = 4,
    parameter  dir_e ARRIVE_DIR = DIR_LOCAL,
    localparam int   OW         = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PKT_W-1:0] in_packet,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PKT_W-1:0] out_packet,
    output logic [4:0]       out_valid,
    input  logic [4:0]       out_ready,
    output logic [OW-1:0]    occupancy,
    output logic             err_pulse,
    output logic [7:0]       err_count
);

    localparam logic signed [COORD_W-1:0] C_ZERO = '0;
    localparam logic signed [COORD_W-1:0] C_ONE  = COORD_W'(1);

    logic [PKT_W-1:0]          head;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic                      hs;
    logic                      can_load;
    logic                      illegal;
    logic signed [COORD_W-1:0] dx;
    logic signed [COORD_W-1:0] dy;
    logic signed [COORD_W-1:0] ndx;
    logic signed [COORD_W-1:0] ndy;
    logic [4:0]                sel;
    logic [PKT_W-1:0]          routed;

    assign in_ready = ~full;
    assign push     = in_valid & ~full;

    noc_fifo #(
        .W     (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push),
        .wr_data   (in_packet),
        .rd_en     (pop),
        .rd_data   (head),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    assign dx = head[PKT_W-1 -: COORD_W];
    assign dy = head[PKT_W-COORD_W-1 -: COORD_W];

    always_comb begin
        ndx = dx;
        ndy = dy;
        sel = '0;
        unique case (1'b1)
            (dx > C_ZERO): begin
                ndx          = dx - C_ONE;
                sel[OV_EAST] = 1'b1;
            end
            (dx < C_ZERO): begin
                ndx          = dx + C_ONE;
                sel[OV_WEST] = 1'b1;
            end
            (dx == C_ZERO && dy > C_ZERO): begin
                ndy           = dy - C_ONE;
                sel[OV_NORTH] = 1'b1;
            end
            (dx == C_ZERO && dy < C_ZERO): begin
                ndy           = dy + C_ONE;
                sel[OV_SOUTH] = 1'b1;
            end
            (dx == C_ZERO && dy == C_ZERO): begin
                sel[OV_LOCAL] = 1'b1;
            end
        endcase
    end

    assign routed = {ndx, ndy, head[PKT_W-2*COORD_W-1:0]};

    // A packet may not reverse or turn back out of the Y dimension
    always_comb begin
        illegal = 1'b0;
        case (ARRIVE_DIR)
            DIR_WEST:  illegal = (dx > C_ZERO);
            DIR_EAST:  illegal = (dx < C_ZERO);
            DIR_NORTH: illegal = (dx != C_ZERO) || (dy < C_ZERO);
            DIR_SOUTH: illegal = (dx != C_ZERO) || (dy > C_ZERO);
            default:   illegal = 1'b0;
        endcase
    end

    assign hs       = |(out_valid & out_ready);
    assign can_load = ~|out_valid | hs;
    assign pop      = ~empty & (illegal | can_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_packet <= '0;
            out_valid  <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            err_pulse <= pop & illegal;
            if (pop && illegal && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            if (pop && !illegal) begin
                out_packet <= routed;
                out_valid  <= sel;
            end else if (hs) begin
                out_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_xy_route_stage.sv
// Directed bench: a local-arrival and a west-arrival stage
// share clock and reset; vectors plus corner sequences.
module tb_xy_route_stage;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] l_in_packet, l_out_packet;
    logic        l_in_valid, l_in_ready, l_err_pulse;
    logic [4:0]  l_out_valid, l_out_ready;
    logic [2:0]  l_occ;
    logic [7:0]  l_err_count;

    logic [15:0] w_in_packet, w_out_packet;
    logic        w_in_valid, w_in_ready, w_err_pulse;
    logic [4:0]  w_out_valid, w_out_ready;
    logic [2:0]  w_occ;
    logic [7:0]  w_err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xy_route_stage #(
        .PKT_W (16), .COORD_W (4), .DEPTH (4), .ARRIVE_DIR (DIR_LOCAL)
    ) u_loc (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_packet  (l_in_packet),
        .in_valid   (l_in_valid),
        .in_ready   (l_in_ready),
        .out_packet (l_out_packet),
        .out_valid  (l_out_valid),
        .out_ready  (l_out_ready),
        .occupancy  (l_occ),
        .err_pulse  (l_err_pulse),
        .err_count  (l_err_count)
    );

    xy_route_stage #(
        .PKT_W (16), .COORD_W (4), .DEPTH (4), .ARRIVE_DIR (DIR_WEST)
    ) u_west (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_packet  (w_in_packet),
        .in_valid   (w_in_valid),
        .in_ready   (w_in_ready),
        .out_packet (w_out_packet),
        .out_valid  (w_out_valid),
        .out_ready  (w_out_ready),
        .occupancy  (w_occ),
        .err_pulse  (w_err_pulse),
        .err_count  (w_err_count)
    );

    typedef struct {
        logic [15:0] pkt;
        logic [4:0]  ov;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{16'h3200, 5'b00001, 16'h2200};
        vecs[1] = '{16'hE100, 5'b00010, 16'hF100};
        vecs[2] = '{16'h0300, 5'b00100, 16'h0200};
        vecs[3] = '{16'h0F00, 5'b01000, 16'h0000};
        vecs[4] = '{16'h0000, 5'b10000, 16'h0000};
        vecs[5] = '{16'h8000, 5'b00010, 16'h9000};
        vecs[6] = '{16'h7345, 5'b00001, 16'h6345};
        vecs[7] = '{16'h0823, 5'b01000, 16'h0923};
        vecs[8] = '{16'h00AB, 5'b10000, 16'h00AB};
        vecs[9] = '{16'h0705, 5'b00100, 16'h0605};

        l_in_packet = '0; l_in_valid = 1'b0; l_out_ready = 5'b11111;
        w_in_packet = '0; w_in_valid = 1'b0; w_out_ready = 5'b11111;
        rst_n = 1'b0;
        #1;
        chk("rst_ov", 32'(l_out_valid), 32'h0);
        chk("rst_pkt", 32'(l_out_packet), 32'h0);
        chk("rst_occ", 32'(l_occ), 32'h0);
        chk("rst_err", 32'(l_err_pulse), 32'h0);
        chk("rst_cnt", 32'(w_err_count), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_rdy", 32'(l_in_ready), 32'h1);

        // isolated vectors: 2-cycle latency then one-cycle handshake
        foreach (vecs[i]) begin
            l_in_packet = vecs[i].pkt;
            l_in_valid  = 1'b1;
            step();
            l_in_valid = 1'b0;
            chk($sformatf("lat_ov[%0d]", i), 32'(l_out_valid), 32'h0);
            step();
            chk($sformatf("ov[%0d]", i), 32'(l_out_valid),
                32'(vecs[i].ov));
            chk($sformatf("pkt[%0d]", i), 32'(l_out_packet),
                32'(vecs[i].exp));
            step();
            chk($sformatf("drain[%0d]", i), 32'(l_out_valid), 32'h0);
        end

        // back-to-back stream at one packet per cycle
        l_in_valid  = 1'b1;
        l_in_packet = vecs[0].pkt;
        for (int k = 0; k <= 10; k++) begin
            step();
            if (k + 1 < 10) l_in_packet = vecs[k+1].pkt;
            else l_in_valid = 1'b0;
            chk($sformatf("st_rdy[%0d]", k), 32'(l_in_ready), 32'h1);
            if (k >= 1) begin
                chk($sformatf("st_ov[%0d]", k-1), 32'(l_out_valid),
                    32'(vecs[k-1].ov));
                chk($sformatf("st_pkt[%0d]", k-1), 32'(l_out_packet),
                    32'(vecs[k-1].exp));
            end
        end
        step();
        chk("st_end", 32'(l_out_valid), 32'h0);

        // west arrival: eastbound packet is dropped
        w_in_packet = 16'h1000;
        w_in_valid  = 1'b1;
        step();
        w_in_valid = 1'b0;
        step();
        chk("w_ill_ov", 32'(w_out_valid), 32'h0);
        chk("w_ill_pulse", 32'(w_err_pulse), 32'h1);
        chk("w_ill_cnt", 32'(w_err_count), 32'h1);
        step();
        chk("w_pulse_off", 32'(w_err_pulse), 32'h0);
        chk("w_ill_ov2", 32'(w_out_valid), 32'h0);
        w_in_packet = 16'hF000;
        w_in_valid  = 1'b1;
        step();
        w_in_valid = 1'b0;
        step();
        chk("w_ok_ov", 32'(w_out_valid), 32'h02);
        chk("w_ok_pkt", 32'(w_out_packet), 32'h0000);
        chk("w_ok_pulse", 32'(w_err_pulse), 32'h0);
        step();

        // saturation: 260 more illegal packets on top of the first
        w_in_packet = 16'h3000;
        w_in_valid  = 1'b1;
        for (int k = 0; k < 260; k++) step();
        w_in_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("w_sat_cnt", 32'(w_err_count), 32'd255);
        chk("w_sat_occ", 32'(w_occ), 32'h0);
        chk("w_sat_ov", 32'(w_out_valid), 32'h0);

        // backpressure: 4 in FIFO + 1 in output stage
        l_out_ready = 5'b00000;
        l_in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            l_in_packet = 16'h1000 | 16'(k + 1);
            step();
        end
        l_in_valid = 1'b0;
        chk("bp_rdy", 32'(l_in_ready), 32'h0);
        chk("bp_occ", 32'(l_occ), 32'h4);
        chk("bp_ov", 32'(l_out_valid), 32'h01);
        l_out_ready = 5'b11110;
        step();
        step();
        chk("bp_hold_ov", 32'(l_out_valid), 32'h01);
        chk("bp_hold_pkt", 32'(l_out_packet), 32'h0001);
        chk("bp_hold_occ", 32'(l_occ), 32'h4);
        l_out_ready = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_ov[%0d]", k), 32'(l_out_valid), 32'h01);
            chk($sformatf("bp_pkt[%0d]", k), 32'(l_out_packet),
                32'(k + 1));
            step();
        end
        chk("bp_end_ov", 32'(l_out_valid), 32'h0);
        chk("bp_end_occ", 32'(l_occ), 32'h0);

        // reset with occupancy 3 and output stage holding a packet
        l_out_ready = 5'b00000;
        l_in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            l_in_packet = 16'h0100 | 16'(k);
            step();
        end
        l_in_valid = 1'b0;
        chk("mr_occ_pre", 32'(l_occ), 32'h3);
        chk("mr_ov_pre", 32'(l_out_valid), 32'h04);
        rst_n = 1'b0;
        #1;
        chk("mr_ov", 32'(l_out_valid), 32'h0);
        chk("mr_pkt", 32'(l_out_packet), 32'h0);
        chk("mr_occ", 32'(l_occ), 32'h0);
        chk("mr_wcnt", 32'(w_err_count), 32'h0);
        step();
        rst_n = 1'b1;
        l_out_ready = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("mr_stale[%0d]", k), 32'(l_out_valid), 32'h0);
        end
        chk("mr_rdy", 32'(l_in_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
